ccta_bist: RTL
==============

# ccta_bist

Self-test driver/collector for the CCTA combinational block: the hardware counterpart of the CCTA stimulus bench. On `start` it generates a pseudo-random sequence of {A, B, C, ctrl} vectors, drives them into CCTA, samples the 5-bit `q` response after a configurable settle time, and compresses all responses into a 16-bit signature. It sits beside a CCTA instance and reports `done` with the final signature for software or a tester to read.

## Interface
- `NUM_VECTORS`, 16: vectors per run; legal range 1..255.
- `SEED`, 12'hACE: LFSR seed; 0 is illegal and is replaced by 12'h001.
- `SETTLE`, 1: extra cycles between driving a vector and sampling `q`; legal range 0..15.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `q`  in  5  CCTA response.
- `A`, `B`, `C`  out  4 each  CCTA operands (registered).
- `ctrl`  out  1  CCTA control (registered).
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next `start` or reset.
- `vec_count`  out  8  number of responses captured in the current or last run.
- `signature`  out  16  MISR contents.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1 → RUN:
  - Load LFSR with SEED and clear `signature`, `vec_count`, and the settle counter.
  - Drive vector 0: A=SEED[11:8], B=SEED[7:4], C=SEED[3:0], ctrl=0.
  - Set `busy`=1 and `done`=0.
- RUN, settle counter < SETTLE: increment the counter; hold outputs.
- RUN, settle counter == SETTLE (capture edge):
  - Update `signature` = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {11'b0, q}.
  - Increment `vec_count`.
  - Advance the 12-bit Fibonacci LFSR (x^12+x^6+x^4+x+1, shift left, feedback into bit 0).
  - Drive the next vector: A/B/C = new LFSR nibbles [11:8]/[7:4]/[3:0], ctrl = new `vec_count`[0].
  - Reset the settle counter.
  - If the new `vec_count` == NUM_VECTORS → DONE (`busy`=0, `done`=1), and A/B/C/ctrl hold their last values.
- DONE: `signature` and `vec_count` stay frozen until `start`.
- `start` in RUN is ignored.

## Timing
- Reset values: A=B=C=0, ctrl=0, busy=0, done=0, vec_count=0, signature=0; state IDLE.
- Reset asserted mid-run aborts immediately to the reset values; no partial result is kept.
- The edge that samples `start` also drives vector 0.
- Vector k is driven at edge E_k; `q` is sampled at edge E_k + SETTLE + 1, which is also E_{k+1}.
- `done` rises at start edge + NUM_VECTORS × (SETTLE+1); `busy` falls on the same edge.
- `start` in DONE restarts at the same edge: `done` falls and `busy` rises together.
- All outputs are registered; there is no combinational path from `q` or `start` to any output.

## Configuration
- `CCTA_BIST_GOLDEN_EN` defined:
  - Adds parameter `GOLDEN_SIG` (default 16'h0000) and output `pass` (1 bit).
  - `pass` = `done` && (`signature` == GOLDEN_SIG), registered; reset value 0; cleared on `start`.
- Macro undefined: no `GOLDEN_SIG` parameter and no `pass` port; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 and toggle `start` → all outputs at reset values. Pulse `rst_n` low mid-run → `busy`=0, `signature`=0 within the same cycle.
- NUM_VECTORS=1, SETTLE=1, q tied 5'h00, `start` pulse at edge 0 → A=4'hA, B=4'hC, C=4'hE, ctrl=0 at edge 0; `done`=1 at edge 2; signature=16'h0000; vec_count=1.
- NUM_VECTORS=2, SETTLE=0, q tied 5'h01 → signature 16'h0001 after the first capture, 16'h0003 at `done` (edge 2); ctrl=1 while vector 1 is driven.
- SETTLE=3, NUM_VECTORS=4 → each vector held exactly 4 cycles; `done` at edge 16. A `start` pulse during RUN does not change timing or signature.
- Restart from DONE with `start` → signature cleared, vector 0 re-driven as A=A, B=C, C=E. With q fed from a CCTA instance, the final signature matches the first run.
- `CCTA_BIST_GOLDEN_EN` defined, GOLDEN_SIG=16'h0003, the q=1/2-vector case above → `pass`=1 one cycle after `done`. With GOLDEN_SIG=16'h0004 → `pass` stays 0.

Source files
------------

// File: rtl/ccta_bist.sv
// ccta_bist: LFSR vector driver and MISR response compactor for the CCTA block; optional CCTA_BIST_GOLDEN_EN adds GOLDEN_SIG/pass.
// Latency: done rises NUM_VECTORS*(SETTLE+1) cycles after the edge that samples start; all outputs registered.
// Backpressure: none; start is only honoured in IDLE/DONE and is ignored while a run is in progress.
module ccta_bist #(
    parameter int          NUM_VECTORS = 16,
    parameter logic [11:0] SEED        = 12'hACE,
    parameter int          SETTLE      = 1
`ifdef CCTA_BIST_GOLDEN_EN
    ,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  q,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic        ctrl,
    output logic        busy,
    output logic        done,
    output logic [7:0]  vec_count,
    output logic [15:0] signature
`ifdef CCTA_BIST_GOLDEN_EN
    ,
    output logic        pass
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       ctrl;
    } vec_t;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [11:0] SEED_EFF = (SEED == 12'h000) ? 12'h001 : SEED;
    localparam logic [7:0]  NV       = 8'(NUM_VECTORS);
    localparam logic [3:0]  ST       = 4'(SETTLE);

    state_t      state, state_n;
    logic [11:0] lfsr, lfsr_n, lfsr_adv;
    logic [3:0]  settle_cnt, settle_cnt_n;
    logic [7:0]  vc_n, vc_inc;
    logic [15:0] sig_n, sig_upd;
    vec_t        vec_r, vec_n;
    logic        busy_n, done_n;
    logic        start_acc;

    // x^12+x^6+x^4+x+1, shifting left with feedback into bit 0
    assign lfsr_adv = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
    assign sig_upd  = {signature[14:0], 1'b0}
                    ^ (signature[15] ? 16'h1021 : 16'h0000)
                    ^ {11'b0, q};
    assign vc_inc   = vec_count + 8'd1;
    assign start_acc = start && (state != S_RUN);

    always_comb begin
        state_n      = state;
        lfsr_n       = lfsr;
        settle_cnt_n = settle_cnt;
        vc_n         = vec_count;
        sig_n        = signature;
        vec_n        = vec_r;
        busy_n       = busy;
        done_n       = done;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n      = S_RUN;
                    lfsr_n       = SEED_EFF;
                    settle_cnt_n = 4'd0;
                    vc_n         = 8'd0;
                    sig_n        = 16'h0000;
                    vec_n        = '{a: SEED_EFF[11:8], b: SEED_EFF[7:4], c: SEED_EFF[3:0], ctrl: 1'b0};
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                end
            end
            S_RUN: begin
                if (settle_cnt < ST) begin
                    settle_cnt_n = settle_cnt + 4'd1;
                end else begin
                    sig_n        = sig_upd;
                    vc_n         = vc_inc;
                    lfsr_n       = lfsr_adv;
                    settle_cnt_n = 4'd0;
                    if (vc_inc == NV) begin
                        // last vector stays on the CCTA inputs after completion
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        vec_n = '{a: lfsr_adv[11:8], b: lfsr_adv[7:4], c: lfsr_adv[3:0], ctrl: vc_inc[0]};
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lfsr       <= SEED_EFF;
            settle_cnt <= 4'd0;
            vec_count  <= 8'd0;
            signature  <= 16'h0000;
            vec_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            settle_cnt <= settle_cnt_n;
            vec_count  <= vc_n;
            signature  <= sig_n;
            vec_r      <= vec_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    assign A    = vec_r.a;
    assign B    = vec_r.b;
    assign C    = vec_r.c;
    assign ctrl = vec_r.ctrl;

`ifdef CCTA_BIST_GOLDEN_EN
    // compares the already-registered result, so pass trails done by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (start_acc) begin
            pass <= 1'b0;
        end else begin
            pass <= done && (signature == GOLDEN_SIG);
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
